// File: rtl/l2_config_and_types.sv
// l2_config_and_types
//   Shared definitions for the L2 reservation unit: default parameter values
//   and the request-type enum with its decode helper.
//   Optional feature macro used by the reservation files:
//     L2_RESERVATION_TIMEOUT_EN - builds per-slot reservation lifetime timers.
package l2_config_and_types;

    localparam int DEFAULT_NUM_PORTS      = 4;
    localparam int DEFAULT_GRANULE_LOG2   = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_LR    = 2'd1,
        REQ_SC    = 2'd2,
        REQ_STORE = 2'd3
    } req_kind_e;

    // SC dominates both LR and store; LR beats a plain store.
    function automatic req_kind_e decode_req(input logic lr, input logic sc, input logic store);
        req_kind_e kind;
        if (sc) begin
            kind = REQ_SC;
        end else if (lr) begin
            kind = REQ_LR;
        end else if (store) begin
            kind = REQ_STORE;
        end else begin
            kind = REQ_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/l2_reservation_slot.sv
// l2_reservation_slot
//   One per-port reservation: IDLE/RESERVED state, granule tag and (when
//   L2_RESERVATION_TIMEOUT_EN is defined) a lifetime timer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   granule   - granule tag of the current request
//   reserve   - load the tag and enter RESERVED (LR from this port)
//   revoke    - return to IDLE
//   match     - slot is RESERVED and its tag equals granule (pre-update state)
module l2_reservation_slot
    import l2_config_and_types::*;
#(
    parameter int TAG_W          = 28
`ifdef L2_RESERVATION_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] granule,
    input  logic             reserve,
    input  logic             revoke,
    output logic             match
);

    logic             reserved;
    logic [TAG_W-1:0] tag;

`ifdef L2_RESERVATION_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;

    // Reserve has priority over both revoke and expiry, so an LR landing on
    // the expiry cycle re-arms the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved <= 1'b0;
            tag      <= '0;
            timer    <= '0;
        end else if (reserve) begin
            reserved <= 1'b1;
            tag      <= granule;
            timer    <= RELOAD;
        end else if (revoke) begin
            reserved <= 1'b0;
        end else if (reserved) begin
            if (timer == '0) begin
                reserved <= 1'b0;
            end else begin
                timer <= timer - TIMER_W'(1);
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved <= 1'b0;
            tag      <= '0;
        end else if (reserve) begin
            reserved <= 1'b1;
            tag      <= granule;
        end else if (revoke) begin
            reserved <= 1'b0;
        end
    end
`endif

    assign match = reserved & (tag == granule);

endmodule

// File: rtl/l2_reservation_unit.sv
// l2_reservation_unit
//   LR/SC reservation tracker for an L2 slice. Each accepted request produces
//   one response on the following cycle, held until consumed.
//   Optional feature: define L2_RESERVATION_TIMEOUT_EN to give reservations a
//   lifetime of TIMEOUT_CYCLES; otherwise they persist until revoked.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake
//   req_addr            - word address [31:2]
//   req_id              - issuing port
//   req_lr/sc/store     - request type flags
//   resp_valid/ready    - response handshake
//   resp_abort          - SC failed, must not write
//   resp_id             - port the response belongs to
module l2_reservation_unit
    import l2_config_and_types::*;
#(
    parameter int NUM_PORTS      = DEFAULT_NUM_PORTS,
    parameter int GRANULE_LOG2   = DEFAULT_GRANULE_LOG2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int ID_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:2]     req_addr,
    input  logic [ID_W-1:0] req_id,
    input  logic            req_lr,
    input  logic            req_sc,
    input  logic            req_store,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_abort,
    output logic [ID_W-1:0] resp_id
);

    localparam int          TAG_W       = 30 - GRANULE_LOG2;
    localparam logic [31:0] NUM_PORTS_U = 32'(NUM_PORTS);

    logic [TAG_W-1:0]     granule;
    logic [NUM_PORTS-1:0] match;
    logic [NUM_PORTS-1:0] reserve;
    logic [NUM_PORTS-1:0] revoke;
    logic                 accept;
    logic                 id_ok;
    logic                 act;
    logic                 own_match;
    logic                 abort_next;
    req_kind_e            kind;

    assign granule = req_addr[31:GRANULE_LOG2+2];

    // Word offset inside a granule never takes part in compares.
    if (GRANULE_LOG2 > 0) begin : g_offset
        logic unused_offset;
        assign unused_offset = &{1'b0, req_addr[GRANULE_LOG2+1:2]};
    end

    assign req_ready = ~resp_valid | resp_ready;
    assign accept    = req_valid & req_ready;
    assign id_ok     = 32'(req_id) < NUM_PORTS_U;
    assign act       = accept & id_ok;
    assign kind      = decode_req(req_lr, req_sc, req_store);

    // Requester's own match, guarded against out-of-range ids.
    always_comb begin
        own_match = 1'b0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            if (req_id == ID_W'(q)) begin
                own_match = match[q];
            end
        end
    end

    // Revoke fan-out: a successful SC or any store kills other ports'
    // matching reservations; an SC always clears the requester's own slot.
    always_comb begin
        reserve = '0;
        revoke  = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            reserve[q] = act && (kind == REQ_LR) && (req_id == ID_W'(q));
            revoke[q]  = act &&
                         (((kind == REQ_SC) &&
                           ((req_id == ID_W'(q)) || (own_match && match[q]))) ||
                          ((kind == REQ_STORE) && (req_id != ID_W'(q)) && match[q]));
        end
    end

    assign abort_next = (kind == REQ_SC) & ~(id_ok & own_match);

    for (genvar q = 0; q < NUM_PORTS; q++) begin : g_slot
        l2_reservation_slot #(
            .TAG_W          (TAG_W)
`ifdef L2_RESERVATION_TIMEOUT_EN
           ,.TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .granule (granule),
            .reserve (reserve[q]),
            .revoke  (revoke[q]),
            .match   (match[q])
        );
    end

`ifndef L2_RESERVATION_TIMEOUT_EN
    // Lifetime setting has no effect without timers.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_ignored
    end
`endif

    // Response register: a new accept overwrites a response being consumed
    // in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_abort <= 1'b0;
            resp_id    <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_abort <= abort_next;
            resp_id    <= req_id;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/l2_reservation_unit.md
L2_RESERVATION_UNIT -- requirements
Module: l2_reservation_unit

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requesting ports, at least 1.
REQ-002 SHALL have parameter GRANULE_LOG2, default 2: reservation granule of 2^GRANULE_LOG2 words; addr[GRANULE_LOG2+1:2] is ignored in compares.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: reservation lifetime in cycles; at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-008 req_addr  in  [31:2]  word address.
REQ-009 req_id  in  ID_W  issuing port, where ID_W = max(1, clog2(NUM_PORTS)).
REQ-010 req_lr / req_sc / req_store  in  1 each  load-reserved / store-conditional / store or read-modify-write AMO.
REQ-011 resp_valid  out  1  result valid.
REQ-012 resp_ready  in  1  result consumed.
REQ-013 resp_abort  out  1  the SC failed and must not write.
REQ-014 resp_id  out  ID_W  port the response belongs to.

Function
REQ-015 Handshake: req_ready = ~resp_valid | resp_ready; a request is accepted when req_valid & req_ready.
REQ-016 Each accepted request SHALL give exactly one response on the next cycle, with resp_valid held until resp_ready is high.
REQ-017 Each port slot SHALL be in state IDLE or RESERVED and SHALL hold a granule tag of bits [31:GRANULE_LOG2+2].
REQ-018 Match condition: slot RESERVED and tag equals the request granule.
REQ-019 LR from port p: slot p goes to RESERVED, its tag is loaded and its timer reloaded to TIMEOUT_CYCLES-1; resp_abort = 0; all other slots are unchanged.
REQ-020 SC from port p: resp_abort = ~match(p).
REQ-021 SC from port p: slot p goes to IDLE whether or not the SC succeeds.
REQ-022 SC from port p, if it succeeds: every other slot whose tag matches the request granule goes to IDLE.
REQ-023 Store from port p: every slot q != p that matches goes to IDLE; slot p is unchanged; resp_abort = 0.
REQ-024 A request with none of lr, sc or store asserted: no state change; resp_abort = 0.
REQ-025 lr and sc both high: treated as SC only.
REQ-026 sc and store both high: treated as SC.
REQ-027 A req_id >= NUM_PORTS SHALL change no state and SHALL give resp_abort = 1 when sc is set, else 0.
REQ-028 The match for the current request SHALL use slot state before that request's update; back-to-back requests SHALL see the previous update.
REQ-029 Timer, when enabled, counts down once per cycle while RESERVED; at 0 the slot goes to IDLE on the next edge.
REQ-030 If the timer reaches expiry in the same cycle an LR reloads that slot, the LR SHALL win.

Reset
REQ-031 On rst, all slots SHALL go to IDLE, tags and timers to 0, resp_valid = 0, resp_abort = 0 and resp_id = 0, asynchronously.
REQ-032 A request in flight at reset SHALL be dropped with no response.
REQ-033 req_ready SHALL be 1 during and after reset.

Configuration
REQ-034 With macro L2_RESERVATION_TIMEOUT_EN defined, the per-slot timers (REQ-029, REQ-030) SHALL be built.
REQ-035 Without L2_RESERVATION_TIMEOUT_EN, no timer logic SHALL exist, reservations SHALL persist until revoked, and TIMEOUT_CYCLES SHALL be ignored.

Structure
REQ-036 The request-type enum and the default values of NUM_PORTS, GRANULE_LOG2 and TIMEOUT_CYCLES SHALL live in l2_config_and_types.
REQ-037 Sub-module l2_reservation_slot, instantiated NUM_PORTS times, SHALL hold state, tag, timer and the match compare; the top level SHALL hold the handshake, revoke fan-out and response register.

Verification
REQ-038 LR port 1 at 0x1000, then SC port 1 at 0x1004 (GRANULE_LOG2=2) -> resp_abort=0, resp_id=1, slot 1 IDLE.
REQ-039 LR port 0 at 0x2000, store port 2 at 0x2008, then SC port 0 at 0x2000 -> resp_abort=1.
REQ-040 LR ports 0 and 1 at 0x3000, successful SC port 0 -> a following SC port 1 at 0x3000 gives resp_abort=1.
REQ-041 With TIMEOUT_EN and TIMEOUT_CYCLES=8, LR port 3, idle 8 cycles, then SC -> resp_abort=1; the same SC after 6 cycles -> resp_abort=0.
REQ-042 Hold resp_ready=0 for 3 cycles with req_valid high -> req_ready=0 and the response is stable; release -> exactly one new request is accepted per cycle.
REQ-043 Assert rst mid-LR -> no response; a following SC gives resp_abort=1.
